// File: rtl/dmem_responder.sv
// Word-addressed data memory slave: valid/ready request in, fixed wait states, then a
// held response. Misaligned or out-of-range accesses return an error and never touch memory.
module dmem_responder #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [2**ADDR_BITS];

  logic                 w_accept, w_enter_resp, w_we, w_err;
  logic [31:0]          w_addr, w_wdata;
  logic [ADDR_BITS-1:0] w_idx;

  assign w_accept = (r_state == IDLE) && req_valid;

  // With zero wait states RESP is entered on the accept edge, before the capture
  // registers hold the request, so the live bus stands in for them there.
  assign w_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_err   = (w_addr[1:0] != 2'b00) || (|w_addr[31:ADDR_BITS+2]);
  assign w_idx   = w_addr[ADDR_BITS+1:2];

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: if (r_cnt == 4'd1) begin
        w_next       = RESP;
        w_enter_resp = 1'b1;
      end
      RESP: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_CYCLES);
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (!w_we && !w_err) ? r_mem[w_idx] : 32'd0;
      end
    end
  end

  // Memory is deliberately left out of reset; a reset before the RESP edge drops the store.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_we && !w_err)
      r_mem[w_idx] <= w_wdata;
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 with two wait states, instance 1 with none, both
// tracked by a transaction-level model and checked every cycle, plus literal expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv[2], rrdy[2], we[2], rvld[2], rerr[2], rdy[2], bsy[2];
  logic [31:0] ad[2], wd[2], rdat[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BITS(6), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_addr(ad[0]), .req_wdata(wd[0]), .resp_valid(rvld[0]), .resp_ready(rrdy[0]),
    .resp_rdata(rdat[0]), .resp_err(rerr[0]), .busy(bsy[0]));

  dmem_responder #(.ADDR_BITS(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]), .resp_valid(rvld[1]), .resp_ready(rrdy[1]),
    .resp_rdata(rdat[1]), .resp_err(rerr[1]), .busy(bsy[1]));

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: phase 0 = free, 1 = counting wait states, 2 = response held.
  int          wc[2] = '{2, 0};
  int          ph[2], age[2];
  bit          minit[2];
  bit          cw[2];
  logic [31:0] ca[2], cd[2];
  logic [31:0] exp_rd[2];
  bit          exp_er[2], exp_known[2];
  logic [31:0] mm[2][64];
  bit          mk[2][64];

  task automatic respond(input int i);
    int idx;
    bit bad;
    idx = int'(ca[i] >> 2) % 64;
    bad = (ca[i] % 4 != 0) || (ca[i] >= 32'h100);
    ph[i] = 2;
    exp_er[i] = bad;
    exp_rd[i] = 32'd0;
    exp_known[i] = 1'b1;
    if (!bad && cw[i]) begin
      mm[i][idx] = cd[i];
      mk[i][idx] = 1'b1;
    end else if (!bad) begin
      exp_rd[i] = mm[i][idx];
      exp_known[i] = mk[i][idx];
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ph[i] = 0;
        minit[i] = 1'b1;
      end else if (minit[i]) begin
        case (ph[i])
          0: if (rv[i]) begin
            cw[i] = we[i]; ca[i] = ad[i]; cd[i] = wd[i]; age[i] = 0;
            if (wc[i] == 0) respond(i);
            else ph[i] = 1;
          end
          1: begin
            age[i]++;
            if (age[i] == wc[i]) respond(i);
          end
          default: if (rrdy[i]) ph[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (minit[i]) begin
        chk("req_ready", i, 32'(rdy[i]), 32'(ph[i] == 0));
        chk("resp_valid", i, 32'(rvld[i]), 32'(ph[i] == 2));
        chk("busy", i, 32'(bsy[i]), 32'(ph[i] != 0));
        if (ph[i] == 2) begin
          chk("resp_err", i, 32'(rerr[i]), 32'(exp_er[i]));
          if (exp_known[i]) chk("resp_rdata", i, rdat[i], exp_rd[i]);
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge with the transaction finished.
  task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output logic [31:0] rd, output logic er, output int lat);
    int n;
    rv[i] = 1'b1; we[i] = w; ad[i] = a; wd[i] = d; rrdy[i] = (hold == 0);
    n = 0;
    while (!rdy[i] && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", i, 32'(n < 50), 32'd1);
    @(negedge clk);
    rv[i] = 1'b0;
    lat = 1;
    while (!rvld[i] && lat < 50) begin @(negedge clk); lat++; end
    chk("resp_timeout", i, 32'(lat < 50), 32'd1);
    rd = rdat[i];
    er = rerr[i];
    if (hold > 0) begin
      for (int k = 1; k < hold; k++) begin
        @(negedge clk);
        rv[i] = (k == 2);
      end
      rv[i] = 1'b0;
      rrdy[i] = 1'b1;
      @(negedge clk);
      chk("idle_after_ready", i, 32'(rdy[i]), 32'd1);
      rrdy[i] = 1'b0;
    end else begin
      @(negedge clk);
      rrdy[i] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, nacc, nresp;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rrdy[i] = 0; we[i] = 0; ad[i] = 0; wd[i] = 0;
      ph[i] = 0; age[i] = 0; minit[i] = 0;
      for (int j = 0; j < 64; j++) begin mm[i][j] = 0; mk[i][j] = 0; end
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(rdy[i]), 32'd1);
      chk("rst_valid", i, 32'(rvld[i]), 32'd0);
      chk("rst_busy", i, 32'(bsy[i]), 32'd0);
      chk("rst_rdata", i, rdat[i], 32'd0);
      chk("rst_err", i, 32'(rerr[i]), 32'd0);
    end

    xact(0, 1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_err", 0, 32'(er), 32'd0);
    xact(0, 0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("load_latency", 0, lat, 32'd3);
    chk("load_rdata", 0, rd, 32'hDEADBEEF);
    chk("load_err", 0, 32'(er), 32'd0);

    xact(0, 1, 32'h0, 32'h5555AAAA, 0, rd, er, lat);
    xact(0, 0, 32'h13, 32'h0, 0, rd, er, lat);
    chk("misalign_err", 0, 32'(er), 32'd1);
    chk("misalign_rdata", 0, rd, 32'd0);
    xact(0, 0, 32'h100, 32'h0, 0, rd, er, lat);
    chk("range_err", 0, 32'(er), 32'd1);
    chk("range_rdata", 0, rd, 32'd0);
    xact(0, 1, 32'h102, 32'hFFFFFFFF, 0, rd, er, lat);
    chk("bad_store_err", 0, 32'(er), 32'd1);
    xact(0, 0, 32'h0, 32'h0, 0, rd, er, lat);
    chk("word0_kept", 0, rd, 32'h5555AAAA);

    xact(0, 1, 32'hFC, 32'h0BADF00D, 0, rd, er, lat);
    xact(0, 0, 32'hFC, 32'h0, 5, rd, er, lat);
    chk("top_word_rdata", 0, rd, 32'h0BADF00D);
    chk("top_word_err", 0, 32'(er), 32'd0);

    xact(1, 1, 32'h4, 32'hCAFEF00D, 0, rd, er, lat);
    xact(1, 0, 32'h4, 32'h0, 0, rd, er, lat);
    chk("wc0_latency", 1, lat, 32'd1);
    chk("wc0_rdata", 1, rd, 32'hCAFEF00D);

    rv[1] = 1'b1; we[1] = 1'b0; ad[1] = 32'h4; rrdy[1] = 1'b1;
    nacc = 0; nresp = 0;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_ready_pattern", 1, 32'(rdy[1]), 32'(k % 2 == 0));
      if (rdy[1]) nacc++;
      if (rvld[1]) nresp++;
      @(negedge clk);
    end
    rv[1] = 1'b0;
    @(negedge clk);
    rrdy[1] = 1'b0;
    chk("b2b_accepts", 1, nacc, 32'd4);
    chk("b2b_resps", 1, nresp, 32'd4);

    xact(0, 1, 32'h20, 32'hAAAAAAAA, 0, rd, er, lat);
    rv[0] = 1'b1; we[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h12345678; rrdy[0] = 1'b1;
    @(negedge clk);
    rv[0] = 1'b0;
    chk("in_wait_busy", 0, 32'(bsy[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rrdy[0] = 1'b0;
    chk("abort_ready", 0, 32'(rdy[0]), 32'd1);
    chk("abort_valid", 0, 32'(rvld[0]), 32'd0);
    chk("abort_busy", 0, 32'(bsy[0]), 32'd0);
    chk("abort_rdata", 0, rdat[0], 32'd0);
    chk("abort_err", 0, 32'(rerr[0]), 32'd0);
    xact(0, 0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("abort_no_write", 0, rd, 32'hAAAAAAAA);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
